// File: rtl/cordic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// cordic_phase_sequencer
//
// Upstream control stage for the CORDIC rotator. A full-turn phase accumulator
// is reduced to a first-quadrant angle (Q3.29 radians), one rotation is
// launched per sample with a start/done handshake, and the returned cos/sin
// pair is folded back into the true quadrant before being offered on a
// valid/ready output. This yields full-circle sin/cos even though the rotator
// itself only converges over roughly +/-99.7 degrees.
//
// Ports:
//   i_clock          rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         free-run sample generation while high
//   i_phase_load     load i_phase_init into the accumulator (has priority)
//   i_phase_init     accumulator load value
//   i_phase_inc      per-sample phase increment (unsigned, wraps)
//   o_cordic_start   one-cycle launch pulse to the rotator
//   o_cordic_x_start constant gain-compensated 1.0 (16'h26DD at WIDTH=16)
//   o_cordic_y_start constant 0
//   o_cordic_angle   reduced angle in [0, pi/2), held from launch to capture
//   i_cordic_cosine  rotator cosine result, Q2.14
//   i_cordic_sine    rotator sine result, Q2.14
//   i_cordic_done    rotator completion (rising edge is what counts)
//   o_out_valid      output sample valid
//   i_out_ready      output sample accepted
//   o_out_cos        folded cosine, Q2.14
//   o_out_sin        folded sine, Q2.14
//   o_out_quadrant   quadrant of the emitted sample
//   o_busy           sequencer is not idle
//   o_timeout_err    sticky rotator timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module cordic_phase_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int PHASE_WIDTH = 32,
    parameter int TIMEOUT     = 64
) (
    input  logic                   i_clock,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_phase_load,
    input  logic [PHASE_WIDTH-1:0] i_phase_init,
    input  logic [PHASE_WIDTH-1:0] i_phase_inc,
    output logic                   o_cordic_start,
    output logic [WIDTH-1:0]       o_cordic_x_start,
    output logic [WIDTH-1:0]       o_cordic_y_start,
    output logic [ANGLE_WIDTH-1:0] o_cordic_angle,
    input  logic [WIDTH-1:0]       i_cordic_cosine,
    input  logic [WIDTH-1:0]       i_cordic_sine,
    input  logic                   i_cordic_done,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH-1:0]       o_out_cos,
    output logic [WIDTH-1:0]       o_out_sin,
    output logic [1:0]             o_out_quadrant,
    output logic                   o_busy,
    output logic                   o_timeout_err
);

    // Remainder within a quadrant and the pi/2 scale factor round(pi/2 * 2^29).
    localparam int R_W    = PHASE_WIDTH - 2;
    localparam int K_W    = 30;
    localparam int PROD_W = R_W + K_W;
    localparam logic [K_W-1:0] K_HALF_PI = 30'd843314857;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCALE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t                 r_state;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [1:0]             r_quad;
    logic [PROD_W-1:0]      r_product;
    logic                   r_done_q;
    logic [CNT_W-1:0]       r_wdog;
    logic                   r_cordic_start;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_cos;
    logic [WIDTH-1:0]       r_out_sin;
    logic [1:0]             r_out_quad;
    logic                   r_timeout_err;

    logic [R_W-1:0]         w_rem;
    logic                   w_done_rise;
    logic [WIDTH-1:0]       w_fold_cos;
    logic [WIDTH-1:0]       w_fold_sin;

    // Two's complement negation that maps the most negative code to the most
    // positive one instead of wrapping back onto itself.
    function automatic logic [WIDTH-1:0] satNeg(input logic [WIDTH-1:0] v);
        if (v == MIN_VAL) begin
            return MAX_VAL;
        end
        return -v;
    endfunction

    assign w_rem       = r_phase[R_W-1:0];
    assign w_done_rise = i_cordic_done & ~r_done_q;

    // Rotate the first-quadrant result by q * 90 degrees.
    always_comb begin
        w_fold_cos = i_cordic_cosine;
        w_fold_sin = i_cordic_sine;
        case (r_quad)
            2'd1: begin
                w_fold_cos = satNeg(i_cordic_sine);
                w_fold_sin = i_cordic_cosine;
            end
            2'd2: begin
                w_fold_cos = satNeg(i_cordic_cosine);
                w_fold_sin = satNeg(i_cordic_sine);
            end
            2'd3: begin
                w_fold_cos = i_cordic_sine;
                w_fold_sin = satNeg(i_cordic_cosine);
            end
            default: begin
                w_fold_cos = i_cordic_cosine;
                w_fold_sin = i_cordic_sine;
            end
        endcase
    end

    // Sequencer. The phase register is only advanced in ISSUE, so a sample
    // that is stalled on the output never skips or repeats a phase step.
    // The done edge detector runs every cycle so that a done level left high
    // by a previous operation never looks like a fresh completion.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_quad         <= '0;
            r_product      <= '0;
            r_done_q       <= 1'b0;
            r_wdog         <= '0;
            r_cordic_start <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_cos      <= '0;
            r_out_sin      <= '0;
            r_out_quad     <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_done_q       <= i_cordic_done;
            r_cordic_start <= 1'b0;

            if (i_phase_load) begin
                r_phase <= i_phase_init;
            end else if (r_state == S_ISSUE) begin
                r_phase <= r_phase + i_phase_inc;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_quad         <= r_phase[PHASE_WIDTH-1 -: 2];
                    r_product      <= PROD_W'(w_rem) * PROD_W'(K_HALF_PI);
                    r_cordic_start <= 1'b1;
                    r_state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        r_out_cos   <= w_fold_cos;
                        r_out_sin   <= w_fold_sin;
                        r_out_quad  <= r_quad;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUTPUT;
                    end else if (r_wdog == CNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + CNT_W'(1);
                    end
                end
                S_OUTPUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= i_enable ? S_SCALE : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Truncating the product to angle units gives a value in [0, pi/2).
    assign o_cordic_angle   = ANGLE_WIDTH'(r_product >> R_W);
    assign o_cordic_start   = r_cordic_start;
    assign o_cordic_x_start = WIDTH'(16'h26DD);
    assign o_cordic_y_start = '0;
    assign o_out_valid      = r_out_valid;
    assign o_out_cos        = r_out_cos;
    assign o_out_sin        = r_out_sin;
    assign o_out_quadrant   = r_out_quad;
    assign o_busy           = (r_state != S_IDLE);
    assign o_timeout_err    = r_timeout_err;

endmodule
